result_drainer: RTL and testbench

Output-side counterpart to the operand fetch path. When the systolic array raises `ready`, the block snapshots the full `SYS_ARRAY_LEN` x `SYS_ARRAY_LEN` result matrix from the array's `out` port into a local buffer. It then pulses `clear` so the array can start the next tile, and streams the buffered results to downstream logic one row per handshake. It sits between the systolic array and the result write-back path.

---
 rtl/result_drainer.sv | 131 +++++++++++++
 tb/tb_result_drainer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drainer.sv
// Snapshots the systolic array result tile on a rising ready and streams it out one row per
// handshake. Define RESULT_DRAINER_TRANSPOSE_EN to emit columns instead of rows.
module result_drainer #(
  parameter int unsigned LEN = 4,
  parameter int unsigned DW  = 32,
  localparam int unsigned IW = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ready,
  input  logic [LEN-1:0][LEN-1:0][DW-1:0] out,
  output logic                            clear,
  output logic [LEN-1:0][DW-1:0]          row_data,
  output logic [IW-1:0]                   row_idx,
  output logic                            row_valid,
  input  logic                            row_ack,
  output logic                            busy,
  output logic                            done,
  output logic                            overrun
);

  typedef enum logic [0:0] {StIdle, StDrain} state_e;
  typedef logic [LEN-1:0][LEN-1:0][DW-1:0] mat_t;

  state_e                 state_q, state_d;
  mat_t                   buf_q, buf_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   ready_q;
  logic                   clear_q, clear_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic                   row_valid_q, row_valid_d;
  logic [LEN-1:0][DW-1:0] row_data_q, row_data_d;

  logic                   ready_rise;
  logic                   xfer;
  logic                   load;
  mat_t                   src;
  logic [IW-1:0]          src_idx;

  assign ready_rise = ready & ~ready_q;
  assign xfer       = row_valid_q & row_ack;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    clear_d    = 1'b0;
    done_d     = 1'b0;
    overrun_d  = overrun_q;
    row_data_d = row_data_q;
    load       = 1'b0;
    src        = buf_q;
    src_idx    = idx_q;

    unique case (state_q)
      StIdle: begin
        if (ready_rise) begin
          buf_d   = out;
          idx_d   = '0;
          state_d = StDrain;
          clear_d = 1'b1;
          // Present row 0 straight from the input so it is valid the cycle after capture.
          load    = 1'b1;
          src     = out;
          src_idx = '0;
        end
      end
      StDrain: begin
        // A new tile arriving while draining is dropped; buf keeps the current tile.
        if (ready_rise) overrun_d = 1'b1;
        if (xfer) begin
          if (idx_q == IW'(LEN - 1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IW'(1);
            load    = 1'b1;
            src_idx = idx_q + IW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      for (int unsigned k = 0; k < LEN; k++) begin
`ifdef RESULT_DRAINER_TRANSPOSE_EN
        row_data_d[k] = src[k][src_idx];
`else
        row_data_d[k] = src[src_idx][k];
`endif
      end
    end

    row_valid_d = (state_d == StDrain);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      buf_q       <= '0;
      idx_q       <= '0;
      ready_q     <= 1'b0;
      clear_q     <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      ready_q     <= ready;
      clear_q     <= clear_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
    end
  end

  assign clear     = clear_q;
  assign row_data  = row_data_q;
  assign row_idx   = idx_q;
  assign row_valid = row_valid_q;
  assign busy      = row_valid_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_result_drainer.sv
// Self-checking bench for result_drainer: random tiles and handshake patterns against a
// tile-level reference model.
module tb_result_drainer;
  localparam int LEN = 4;
  localparam int DW  = 32;
  typedef logic [LEN-1:0][DW-1:0] row_t;

  logic                            clk = 1'b0;
  logic                            rst_n = 1'b0;
  logic                            ready = 1'b0;
  logic                            row_ack = 1'b0;
  logic [LEN-1:0][LEN-1:0][DW-1:0] out_s = '0;
  logic                            clear, row_valid, busy, done, overrun;
  row_t                            row_data;
  logic [1:0]                      row_idx;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_m [LEN][LEN];

  result_drainer #(.LEN(LEN), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .out      (out_s),
    .clear    (clear),
    .row_data (row_data),
    .row_idx  (row_idx),
    .row_valid(row_valid),
    .row_ack  (row_ack),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Reference: the row (or column, when transposed) k of the captured tile.
  function automatic row_t exp_row(input int k);
    row_t r;
    for (int c = 0; c < LEN; c++) begin
`ifdef RESULT_DRAINER_TRANSPOSE_EN
      r[c] = exp_m[c][k];
`else
      r[c] = exp_m[k][c];
`endif
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: random, 1: i*LEN+j, 2: all 60.0
  task automatic set_tile(input int mode);
    for (int i = 0; i < LEN; i++)
      for (int j = 0; j < LEN; j++)
        out_s[i][j] = (mode == 0) ? $urandom : (mode == 1) ? DW'(i * LEN + j) : 32'h4270_0000;
  endtask

  task automatic latch_model;
    for (int i = 0; i < LEN; i++)
      for (int j = 0; j < LEN; j++) exp_m[i][j] = out_s[i][j];
  endtask

  task automatic do_reset;
    ready   = 1'b0;
    row_ack = 1'b0;
    rst_n   = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ready = 1'b1;
    set_tile(0);
    #2;
    checks++;
    if ({clear, row_valid, row_data, row_idx, busy, done, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got clear=%b valid=%b idx=%0d busy=%b done=%b ovr=%b data=%h",
               clear, row_valid, row_idx, busy, done, overrun, row_data);
    end
    tick;
    rst_n = 1'b1;
    latch_model();
    tick;
    checks++;
    if (clear !== 1'b1 || row_valid !== 1'b1 || row_idx !== 2'd0 || row_data !== exp_row(0)) begin
      errors++;
      $display("FAIL ready_at_release: got clear=%b valid=%b idx=%0d, want 1 1 0", clear,
               row_valid, row_idx);
    end
    ready = 1'b0;
  endtask

  task automatic test_basic;
    do_reset();
    set_tile(2);
    latch_model();
    ready   = 1'b1;
    row_ack = 1'b1;
    tick;
    ready = 1'b0;
    for (int r = 0; r < LEN; r++) begin
      checks++;
      if (row_valid !== 1'b1 || busy !== 1'b1 || row_idx !== 2'(r) || row_data !== exp_row(r) ||
          clear !== (r == 0) || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_row%0d: got valid=%b busy=%b idx=%0d clear=%b done=%b data=%h", r,
                 row_valid, busy, row_idx, clear, done, row_data);
      end
      tick;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || row_valid !== 1'b0 || clear !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got done=%b busy=%b valid=%b, want 1 0 0", done, busy, row_valid);
    end
    tick;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b want 0", done);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    for (int round = 0; round < 4; round++) begin
      int   cnt   = 0;
      int   cyc   = 0;
      logic stall = 1'b0;
      row_t prev_data;
      logic [1:0] prev_idx;
      set_tile(round == 0 ? 1 : 0);
      latch_model();
      ready = 1'b1;
      tick;
      ready = 1'b0;
      while (cnt < LEN && cyc < 100) begin
        logic ack;
        checks++;
        if (row_valid !== 1'b1 || row_idx !== 2'(cnt) || row_data !== exp_row(cnt)) begin
          errors++;
          $display("FAIL bp_r%0d_row%0d: got valid=%b idx=%0d data=%h want idx=%0d data=%h",
                   round, cnt, row_valid, row_idx, row_data, cnt, exp_row(cnt));
        end
        if (stall) begin
          checks++;
          if (row_data !== prev_data || row_idx !== prev_idx) begin
            errors++;
            $display("FAIL bp_stall_stable: got idx=%0d data=%h want idx=%0d data=%h", row_idx,
                     row_data, prev_idx, prev_data);
          end
        end
        ack       = (round == 0) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
        row_ack   = ack;
        stall     = ~ack;
        prev_data = row_data;
        prev_idx  = row_idx;
        tick;
        if (ack) cnt++;
        cyc++;
      end
      row_ack = 1'b0;
      checks++;
      if (cnt != LEN || done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_r%0d_done: got rows=%0d done=%b busy=%b want %0d 1 0", round, cnt, done,
                 busy, LEN);
      end
      tick;
    end
  endtask

  task automatic test_overrun;
    int   cnt = 0;
    int   cyc = 0;
    logic injected = 1'b0;
    do_reset();
    set_tile(0);
    latch_model();
    ready = 1'b1;
    tick;
    ready = 1'b0;
    while (cnt < LEN && cyc < 100) begin
      logic ack;
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 2'(cnt) || row_data !== exp_row(cnt)) begin
        errors++;
        $display("FAIL ovr_row%0d: got valid=%b idx=%0d data=%h want data=%h", cnt, row_valid,
                 row_idx, row_data, exp_row(cnt));
      end
      ready = 1'b0;
      if (cnt == 1 && !injected) begin
        set_tile(0);
        ready    = 1'b1;
        injected = 1'b1;
      end
      ack     = 1'($urandom_range(0, 1));
      row_ack = ack;
      tick;
      if (ack) cnt++;
      cyc++;
    end
    ready   = 1'b0;
    row_ack = 1'b0;
    checks++;
    if (cnt != LEN || done !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_flag: got rows=%0d done=%b overrun=%b want %0d 1 1", cnt, done, overrun,
               LEN);
    end
    tick;
    tick;
    set_tile(0);
    latch_model();
    ready   = 1'b1;
    row_ack = 1'b1;
    tick;
    ready = 1'b0;
    checks++;
    if (clear !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_recapture: got clear=%b overrun=%b want 1 1", clear, overrun);
    end
    for (int r = 0; r < LEN; r++) begin
      checks++;
      if (row_idx !== 2'(r) || row_data !== exp_row(r)) begin
        errors++;
        $display("FAIL ovr_third_row%0d: got idx=%0d data=%h want data=%h", r, row_idx, row_data,
                 exp_row(r));
      end
      tick;
    end
    checks++;
    if (done !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: got done=%b overrun=%b want 1 1", done, overrun);
    end
    row_ack = 1'b0;
  endtask

  task automatic test_level_ready;
    int dones = 0;
    int clears = 0;
    do_reset();
    set_tile(0);
    latch_model();
    ready   = 1'b1;
    row_ack = 1'b1;
    for (int c = 0; c < LEN + 8; c++) begin
      tick;
      dones  += int'(done);
      clears += int'(clear);
      if (c < LEN) begin
        checks++;
        if (row_idx !== 2'(c) || row_data !== exp_row(c)) begin
          errors++;
          $display("FAIL level_row%0d: got idx=%0d data=%h", c, row_idx, row_data);
        end
      end
    end
    checks++;
    if (dones != 1 || clears != 1 || overrun !== 1'b0 || row_valid !== 1'b0) begin
      errors++;
      $display("FAIL level_single: got dones=%0d clears=%0d overrun=%b valid=%b want 1 1 0 0",
               dones, clears, overrun, row_valid);
    end
    ready   = 1'b0;
    row_ack = 1'b0;
  endtask

  task automatic test_reset_mid_drain;
    do_reset();
    set_tile(0);
    latch_model();
    ready   = 1'b1;
    row_ack = 1'b1;
    tick;
    ready = 1'b0;
    tick;
    tick;
    checks++;
    if (row_idx !== 2'd2) begin
      errors++;
      $display("FAIL mid_pre_idx: got %0d want 2", row_idx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (row_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || row_idx !== 2'd0) begin
      errors++;
      $display("FAIL mid_async_reset: got valid=%b busy=%b done=%b idx=%0d want 0 0 0 0",
               row_valid, busy, done, row_idx);
    end
    tick;
    rst_n = 1'b1;
    tick;
    set_tile(0);
    latch_model();
    ready = 1'b1;
    tick;
    ready = 1'b0;
    for (int r = 0; r < LEN; r++) begin
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 2'(r) || row_data !== exp_row(r)) begin
        errors++;
        $display("FAIL mid_new_row%0d: got valid=%b idx=%0d data=%h", r, row_valid, row_idx,
                 row_data);
      end
      tick;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL mid_new_done: got %b want 1", done);
    end
    row_ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    set_tile(0);
    latch_model();
    ready   = 1'b1;
    row_ack = 1'b1;
    tick;
    ready = 1'b0;
    for (int r = 0; r < LEN; r++) tick;
    // Rise at edge T+LEN+1: earliest edge that must be accepted.
    set_tile(0);
    latch_model();
    ready = 1'b1;
    tick;
    ready = 1'b0;
    checks++;
    if (clear !== 1'b1 || row_valid !== 1'b1 || row_idx !== 2'd0 || row_data !== exp_row(0) ||
        overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_capture: got clear=%b valid=%b idx=%0d overrun=%b data=%h", clear,
               row_valid, row_idx, overrun, row_data);
    end
    for (int r = 0; r < LEN; r++) tick;
    checks++;
    if (done !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: got done=%b overrun=%b want 1 0", done, overrun);
    end
    row_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_level_ready();
    test_reset_mid_drain();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
